sc_fifo: RTL and testbench
==========================

// Module: sc_fifo
// PURPOSE
//  Single-clock FIFO built on an internal simple dual-port RAM (one write port, one registered read port).
//  Used as an elastic buffer between pipeline stages, e.g. the frame-ordered IDCT coefficient buffer after dct-type reordering.
//  Standard (non first-word-fall-through) read.
//  Provides full/empty, programmable-threshold flags, and write-ack/valid/overflow/underflow strobes.
// PARAMETERS
//  addr_width   6    RAM address bits; depth D = 2**addr_width entries
//  dta_width    72   data word width in bits
//  prog_thresh  32   threshold for prog_full/prog_empty, in entries (1..D)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, asynchronous, active-high
//  din        in   dta_width   write data
//  wr_en      in   1           write request
//  full       out  1           FIFO holds D entries
//  wr_ack     out  1           previous-cycle write accepted
//  overflow   out  1           previous-cycle write rejected (FIFO was full)
//  prog_full  out  1           count > D - prog_thresh, i.e. fewer than prog_thresh free entries
//  dout       out  dta_width   read data, registered
//  rd_en      in   1           read request
//  empty      out  1           FIFO holds 0 entries
//  valid      out  1           dout updated by previous-cycle accepted read
//  underflow  out  1           previous-cycle read rejected (FIFO was empty)
//  prog_empty out  1           count < prog_thresh
// BEHAVIOUR
//  Reset (async on rst=1):
//   - wr_ptr = rd_ptr = 0, count = 0
//   - empty = 1, prog_empty = 1; full = prog_full = 0
//   - wr_ack = valid = overflow = underflow = 0; dout = 0
//   - RAM contents are not cleared
//  State:
//   - wr_ptr and rd_ptr are addr_width bits and wrap modulo D.
//   - count is addr_width+1 bits, range 0..D.
//  Write: accepted iff wr_en && !full. Then, at the clock edge:
//   - RAM[wr_ptr] <= din, wr_ptr++
//   - wr_ack = 1 for the next cycle
//  Write with wr_en && full:
//   - ignored; no RAM, pointer or count change
//   - overflow = 1 for the next cycle
//   - a simultaneous read does not make room in the same cycle
//  Read: accepted iff rd_en && !empty. Then, at the clock edge:
//   - dout <= RAM[rd_ptr], rd_ptr++
//   - valid = 1 for the next cycle; latency rd_en -> dout/valid is 1 clock
//  Read with rd_en && empty:
//   - dout holds its value
//   - underflow = 1 for the next cycle
//   - a simultaneous write does not bypass to dout
//  dout holds its last value whenever no read is accepted.
//  count update per edge: +1 for write only, -1 for read only, unchanged if both or neither are accepted.
//  full, empty, prog_full, prog_empty are registered, derived from the next count.
//   - They are valid in the cycle after the causing edge.
//   - A write is visible as !empty one cycle later; the earliest read of that word is then 1 cycle after that.
//  Strobes (wr_ack, overflow, valid, underflow) are single-cycle pulses; they stay high on back-to-back qualifying cycles.
//  Full throughput: 1 write and 1 read per cycle sustained.
//  Flag transitions with D=64, prog_thresh=32:
//   - 32 -> 33 entries: prog_full asserts
//   - 31 -> 32 entries: prog_empty deasserts
//   - 64 entries: full
//  rst asserted mid-operation discards all contents immediately and forces the reset values above.
//  No X propagation: all outputs are defined after reset. The internal RAM read port is registered (dout is the RAM output register).
// TESTING
//  T1 reset: assert rst -> empty=1, prog_empty=1, full=0, prog_full=0, all strobes 0, dout=0.
//  T2 order/latency: write 0x11,0x22,0x33, then rd_en x3 -> dout 0x11,0x22,0x33, each with valid 1 cycle after rd_en.
//  T3 fill: write 64 words -> prog_full rises after word 33, full after word 64.
//     A 65th write -> overflow pulse; data is unchanged and readback is the 64 original words.
//  T4 drain: read from empty -> underflow pulse, valid=0, dout holds.
//     Reading all entries -> empty=1; prog_empty=1 once count < 32.
//  T5 simultaneous: at count=10, wr_en&rd_en for 20 cycles -> count stays 10, data order preserved.
//     At count=64, wr_en&rd_en -> write rejected (overflow) and read accepted.
//  T6 pointer wrap: stream 200 words with random wr_en/rd_en gaps; compare against a reference queue.

Source files
------------

// File: rtl/sc_fifo.sv
// ============================================================================
//  Module      : sc_fifo
//  Description : Single-clock standard-read FIFO on a simple dual-port RAM
//                with registered read port, threshold flags and status strobes.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sc_fifo #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DTA_WIDTH   = 72,
  parameter int PROG_THRESH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DTA_WIDTH-1:0] din,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 wr_ack,
  output logic                 overflow,
  output logic                 prog_full,
  output logic [DTA_WIDTH-1:0] dout,
  input  logic                 rd_en,
  output logic                 empty,
  output logic                 valid,
  output logic                 underflow,
  output logic                 prog_empty
);

  localparam int                DEPTH_INT = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH + 1)'(DEPTH_INT);
  localparam logic [ADDR_WIDTH:0] c_pf_level = (ADDR_WIDTH + 1)'(DEPTH_INT - PROG_THRESH);
  localparam logic [ADDR_WIDTH:0] c_pe_level = (ADDR_WIDTH + 1)'(PROG_THRESH);

  logic [DTA_WIDTH-1:0]  mem [DEPTH_INT];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Acceptance uses the registered flags, so a read never frees space for a
  // same-cycle write and a write never bypasses to a same-cycle read.
  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + (ADDR_WIDTH + 1)'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - (ADDR_WIDTH + 1)'(1);
    end
  end

  // Storage array is left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      dout       <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        dout     <= mem[r_rd_ptr];
      end
      r_count    <= w_count_nxt;
      full       <= (w_count_nxt == c_depth);
      empty      <= (w_count_nxt == '0);
      prog_full  <= (w_count_nxt > c_pf_level);
      prog_empty <= (w_count_nxt < c_pe_level);
      wr_ack     <= w_wr_acc;
      overflow   <= wr_en && full;
      valid      <= w_rd_acc;
      underflow  <= rd_en && empty;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sc_fifo.sv
// ============================================================================
//  Module      : tb_sc_fifo
//  Description : Self-checking bench for sc_fifo against a queue reference.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sc_fifo;

  localparam int AW = 6;
  localparam int DW = 72;
  localparam int PT = 32;
  localparam int D  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          rd_en;
  logic          full, wr_ack, overflow, prog_full;
  logic          empty, valid, underflow, prog_empty;
  logic [DW-1:0] dout;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  int            checks   = 0;
  int            failures = 0;
  string         phase;

  always #5 clk = ~clk;

  sc_fifo #(
    .ADDR_WIDTH (AW),
    .DTA_WIDTH  (DW),
    .PROG_THRESH(PT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .wr_en     (wr_en),
    .full      (full),
    .wr_ack    (wr_ack),
    .overflow  (overflow),
    .prog_full (prog_full),
    .dout      (dout),
    .rd_en     (rd_en),
    .empty     (empty),
    .valid     (valid),
    .underflow (underflow),
    .prog_empty(prog_empty)
  );

  function automatic logic [DW-1:0] rnd_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the number of stored entries.
  task automatic chk_all(input logic wa, input logic ra, input logic w, input logic r);
    int n;
    n = q.size();
    chk("dout",       dout,       exp_dout);
    chk("empty",      empty,      DW'(n == 0));
    chk("full",       full,       DW'(n == D));
    chk("prog_full",  prog_full,  DW'(n > D - PT));
    chk("prog_empty", prog_empty, DW'(n < PT));
    chk("wr_ack",     wr_ack,     DW'(wa));
    chk("overflow",   overflow,   DW'(w && !wa));
    chk("valid",      valid,      DW'(ra));
    chk("underflow",  underflow,  DW'(r && !ra));
  endtask

  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    logic wa, ra;
    wr_en = w;
    rd_en = r;
    din   = d;
    wa = w && (q.size() < D);
    ra = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_all(wa, ra, w, r);
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
  endtask

  initial begin
    int written;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_reset();

    // T1 reset values
    phase = "T1_reset";
    #12;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // T2 ordering and one-cycle read latency
    phase = "T2_order";
    cyc(1'b1, 1'b0, DW'(72'h11));
    cyc(1'b1, 1'b0, DW'(72'h22));
    cyc(1'b1, 1'b0, DW'(72'h33));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
    phase = "T2_idle";
    cyc(1'b0, 1'b0, '0);
    chk("dout_last", dout, DW'(72'h33));

    // T3 fill to full, then one rejected write
    phase = "T3_fill";
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, rnd_word());
    chk("full_at_64", full, DW'(1));
    phase = "T3_overflow";
    cyc(1'b1, 1'b0, rnd_word());
    cyc(1'b0, 1'b0, '0);

    // T4 drain all, then read from empty
    phase = "T4_drain";
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, '0);
    chk("empty_after_drain", empty, DW'(1));
    phase = "T4_underflow";
    cyc(1'b0, 1'b1, '0);
    cyc(1'b1, 1'b1, rnd_word());
    cyc(1'b0, 1'b1, '0);

    // T5 simultaneous read/write at count 10 and at full
    phase = "T5_fill10";
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, rnd_word());
    phase = "T5_rw10";
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, rnd_word());
    chk("prog_empty_at10", prog_empty, DW'(1));
    phase = "T5_fill64";
    for (int i = 0; i < D - 10; i++) cyc(1'b1, 1'b0, rnd_word());
    phase = "T5_rw64";
    cyc(1'b1, 1'b1, rnd_word());
    cyc(1'b0, 1'b0, '0);
    phase = "T5_drain";
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, '0);

    // Asynchronous reset in the middle of traffic
    phase = "RST_mid";
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, rnd_word());
    cyc(1'b0, 1'b1, '0);
    rst = 1'b1;
    #2;
    model_reset();
    chk_all(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    phase = "RST_after";
    cyc(1'b0, 1'b1, '0);

    // T6 random stream with pointer wrap
    phase = "T6_stream";
    written = 0;
    for (int i = 0; i < 3000 && written < 200; i++) begin
      logic w, r;
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (w && q.size() < D) written++;
      cyc(w, r, rnd_word());
    end
    chk("t6_written", DW'(written), DW'(200));
    phase = "T6_drain";
    for (int i = 0; i < D + 2; i++) cyc(1'b0, 1'b1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
